// File: rtl/reg_file_pkg.sv
// Shared types and default parameter values for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two write ports, mark port, packed read ports, status.
interface reg_file_mp_if #(
  parameter int DATA_W = reg_file_pkg::DEF_DATA_W,
  parameter int DEPTH  = reg_file_pkg::DEF_DEPTH,
  parameter int NUM_RD = reg_file_pkg::DEF_NUM_RD
);
  localparam int ADDR_W = $clog2(DEPTH);

  // No valid/ready handshake: each strobe acts at the next rising edge only
  // while ready=1; ready is a level status and strobes are never back-pressured.
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rpend;
  logic                     mark_en;
  logic [ADDR_W-1:0]        mark_addr;
  logic                     clr_req;
  logic                     ready;
  reg_file_pkg::state_e     state;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1,
    output raddr, mark_en, mark_addr, clr_req,
    input  rdata, rpend, ready, state
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  raddr, mark_en, mark_addr, clr_req,
    output rdata, rpend, ready, state
  );

endinterface

// File: rtl/reg_file_bypass.sv
// One read port: zero-register check, same-cycle write bypass and pending gating.
module reg_file_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              run_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              wr0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              wr1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [DATA_W-1:0] arr_data_i,
  input  logic              arr_pend_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rpend_o
);

  logic hit0;
  logic hit1;
  logic is_zero;

  assign hit0    = wr0_i && (waddr0_i == raddr_i);
  assign hit1    = wr1_i && (waddr1_i == raddr_i);
  assign is_zero = (ZERO_REG != 0) && (raddr_i == '0);

  // wr0_i/wr1_i are already the accepted writes, so the bypass matches what lands in the array.
  always_comb begin
    rdata_o = '0;
    rpend_o = 1'b0;
    if (run_i && !is_zero) begin
      if (hit1)      rdata_o = wdata1_i;
      else if (hit0) rdata_o = wdata0_i;
      else           rdata_o = arr_data_i;
      rpend_o = arr_pend_i && !hit0 && !hit1;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write flip-flop register file with pending bits and a clear FSM.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_e             state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic               ready_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]   pend_q;
  logic [DEPTH-1:0]   pend_d;

  logic run;
  logic zero_en;
  logic acc0;
  logic acc1;
  logic mark_acc;

  assign run      = (state_q == ST_RUN);
  assign zero_en  = (ZERO_REG != 0);
  assign acc0     = run && bus.we0 && !(zero_en && (bus.waddr0 == '0));
  assign acc1     = run && bus.we1 && !(zero_en && (bus.waddr1 == '0));
  assign mark_acc = run && bus.mark_en && !(zero_en && (bus.mark_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.clr_req) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          idx_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Port 1 is applied after port 0 so it wins a same-address collision; mark is last so it wins over a write.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (!run) begin
      mem_d[idx_q]  = '0;
      pend_d[idx_q] = 1'b0;
    end else begin
      if (acc0) begin
        mem_d[bus.waddr0]  = bus.wdata0;
        pend_d[bus.waddr0] = 1'b0;
      end
      if (acc1) begin
        mem_d[bus.waddr1]  = bus.wdata1;
        pend_d[bus.waddr1] = 1'b0;
      end
      if (mark_acc) pend_d[bus.mark_addr] = 1'b1;
    end
  end

  // Array contents are wiped by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

    reg_file_bypass #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_byp (
      .run_i      (run),
      .raddr_i    (ra),
      .wr0_i      (acc0),
      .waddr0_i   (bus.waddr0),
      .wdata0_i   (bus.wdata0),
      .wr1_i      (acc1),
      .waddr1_i   (bus.waddr1),
      .wdata1_i   (bus.wdata1),
      .arr_data_i (mem_q[ra]),
      .arr_pend_i (pend_q[ra]),
      .rdata_o    (bus.rdata[i*DATA_W +: DATA_W]),
      .rpend_o    (bus.rpend[i])
    );
  end

  assign bus.ready = ready_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomized checks of reg_file_mp against a behavioural register-file model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD)) bus ();

  reg_file_mp #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .NUM_RD   (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_run;
  int            m_left;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(int p);
    return bus.rdata[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] exp_rdata(int a);
    if (!m_run || a == 0) return '0;
    if (bus.we1 && int'(bus.waddr1) == a) return bus.wdata1;
    if (bus.we0 && int'(bus.waddr0) == a) return bus.wdata0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rpend(int a);
    bit wr_hit;
    wr_hit = (bus.we1 && int'(bus.waddr1) == a) || (bus.we0 && int'(bus.waddr0) == a);
    return m_run && (a != 0) && m_pend[a] && !wr_hit;
  endfunction

  task automatic model_wipe();
    for (int a = 0; a < DEPTH; a++) begin
      m_mem[a]  = '0;
      m_pend[a] = 1'b0;
    end
    m_run  = 1'b0;
    m_left = DEPTH;
  endtask

  // Update the model with the inputs present at the edge just taken.
  task automatic model_edge();
    if (rst) begin
      model_wipe();
    end else if (!m_run) begin
      m_left--;
      if (m_left == 0) m_run = 1'b1;
    end else if (bus.clr_req) begin
      model_wipe();
    end else begin
      if (bus.we0 && bus.waddr0 != 0) begin
        m_mem[bus.waddr0]  = bus.wdata0;
        m_pend[bus.waddr0] = 1'b0;
      end
      if (bus.we1 && bus.waddr1 != 0) begin
        m_mem[bus.waddr1]  = bus.wdata1;
        m_pend[bus.waddr1] = 1'b0;
      end
      if (bus.mark_en && bus.mark_addr != 0) m_pend[bus.mark_addr] = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.we0       = 1'b0;
    bus.waddr0    = '0;
    bus.wdata0    = '0;
    bus.we1       = 1'b0;
    bus.waddr1    = '0;
    bus.wdata1    = '0;
    bus.raddr     = '0;
    bus.mark_en   = 1'b0;
    bus.mark_addr = '0;
    bus.clr_req   = 1'b0;
  endtask

  task automatic set_raddr(int p, int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic settle_check(string tag);
    #1;
    chk({tag, "_ready"}, DW'(bus.ready), DW'(m_run));
    for (int i = 0; i < NRD; i++) begin
      int a;
      a = int'(bus.raddr[i*AW +: AW]);
      chk($sformatf("%s_rdata%0d", tag, i), rd(i), exp_rdata(a));
      chk($sformatf("%s_rpend%0d", tag, i), DW'(bus.rpend[i]), DW'(exp_rpend(a)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 5) == 0) return 0;
    return int'($urandom_range(0, 11));
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    settle_check("rst_hold");
    tick();
    rst = 1'b0;

    // Ready after exactly DEPTH clearing edges.
    n = 0;
    while (!bus.ready && n < 100) begin
      settle_check("init");
      tick();
      n++;
    end
    chk("ready_latency", DW'(n), DW'(DEPTH));

    for (int a = 0; a < DEPTH; a++) begin
      set_raddr(0, a);
      set_raddr(1, DEPTH - 1 - a);
      settle_check("init_read");
      chk("init_zero0", rd(0), '0);
      chk("init_zero1", rd(1), '0);
      tick();
    end

    // Same-cycle bypass then array read.
    idle();
    bus.we0 = 1'b1; bus.waddr0 = 5; bus.wdata0 = 32'hDEADBEEF;
    set_raddr(0, 5);
    settle_check("byp");
    chk("byp_same", rd(0), 32'hDEADBEEF);
    tick();
    idle(); set_raddr(0, 5);
    settle_check("byp_next");
    chk("byp_next", rd(0), 32'hDEADBEEF);
    tick();

    // Port 1 wins a same-address collision.
    idle();
    bus.we0 = 1'b1; bus.waddr0 = 7; bus.wdata0 = 32'h11;
    bus.we1 = 1'b1; bus.waddr1 = 7; bus.wdata1 = 32'h22;
    set_raddr(0, 7);
    settle_check("coll");
    chk("coll_same", rd(0), 32'h22);
    tick();
    idle(); set_raddr(0, 7);
    settle_check("coll_next");
    chk("coll_next", rd(0), 32'h22);
    tick();

    // Pending bit set, cleared by write, mark beats write.
    idle();
    bus.mark_en = 1'b1; bus.mark_addr = 9; set_raddr(1, 9);
    settle_check("mark");
    tick();
    idle(); set_raddr(1, 9);
    settle_check("mark_set");
    chk("mark_set", DW'(bus.rpend[1]), 1);
    tick();
    bus.we0 = 1'b1; bus.waddr0 = 9; bus.wdata0 = 32'h5;
    settle_check("wr_pend");
    chk("wr_pend_gate", DW'(bus.rpend[1]), 0);
    chk("wr_pend_data", rd(1), 32'h5);
    tick();
    idle(); set_raddr(1, 9);
    settle_check("pend_clr");
    chk("pend_clr", DW'(bus.rpend[1]), 0);
    bus.mark_en = 1'b1; bus.mark_addr = 9;
    bus.we1 = 1'b1; bus.waddr1 = 9; bus.wdata1 = 32'h6;
    settle_check("mark_wr");
    tick();
    idle(); set_raddr(1, 9);
    settle_check("mark_wins");
    chk("mark_wins_pend", DW'(bus.rpend[1]), 1);
    chk("mark_wins_data", rd(1), 32'h6);
    tick();

    // Entry 0 is hardwired zero and never pending.
    idle();
    bus.we0 = 1'b1; bus.waddr0 = 0; bus.wdata0 = 32'hFFFF;
    bus.mark_en = 1'b1; bus.mark_addr = 0; set_raddr(0, 0);
    settle_check("zero");
    chk("zero_same", rd(0), '0);
    tick();
    idle(); set_raddr(0, 0);
    settle_check("zero_next");
    chk("zero_data", rd(0), '0);
    chk("zero_pend", DW'(bus.rpend[0]), 0);
    tick();

    // Clear request: writes, marks and repeated clr_req ignored while clearing.
    idle();
    bus.we0 = 1'b1; bus.waddr0 = 3; bus.wdata0 = 32'hA;
    settle_check("pre_clr");
    tick();
    idle(); bus.clr_req = 1'b1;
    settle_check("clr");
    tick();
    n = 0;
    while (!bus.ready && n < 100) begin
      idle();
      bus.we0 = 1'b1; bus.waddr0 = 3; bus.wdata0 = 32'h77;
      bus.mark_en = 1'b1; bus.mark_addr = 3; bus.clr_req = 1'b1;
      set_raddr(0, 3);
      settle_check("clearing");
      tick();
      n++;
    end
    chk("clr_latency", DW'(n), DW'(DEPTH));
    idle(); set_raddr(0, 3);
    settle_check("post_clr");
    chk("post_clr_data", rd(0), '0);
    chk("post_clr_pend", DW'(bus.rpend[0]), 0);
    tick();

    // Randomized traffic, including occasional clears and resets.
    for (int c = 0; c < 700; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.we0       = $urandom_range(0, 1);
      bus.waddr0    = AW'(rand_addr());
      bus.wdata0    = $urandom;
      bus.we1       = $urandom_range(0, 2) == 0;
      bus.waddr1    = ($urandom_range(0, 2) == 0) ? bus.waddr0 : AW'(rand_addr());
      bus.wdata1    = $urandom;
      bus.mark_en   = $urandom_range(0, 2) == 0;
      bus.mark_addr = ($urandom_range(0, 3) == 0) ? bus.waddr0 : AW'(rand_addr());
      bus.clr_req   = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 2) == 0) set_raddr(p, int'(bus.waddr0));
        else                           set_raddr(p, rand_addr());
      end
      settle_check("rand");
      tick();
    end
    rst = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
